// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter that shares one single-port SRAM between a
//            read-only fetch requester and a read/write execute requester.
//            Only one access is in flight at a time.
//            Access flow: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
// Ports    : clk, reset_n            clock, async active-low reset
//            i_f_req/i_f_addr        fetch request (read only)
//            o_f_gnt/o_f_valid/o_f_rdata   fetch grant, response, read data
//            i_x_req/i_x_we/i_x_addr/i_x_wdata  execute request
//            o_x_gnt/o_x_valid/o_x_rdata   execute grant, response, read data
//            o_mem_cs/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata  SRAM port
//            o_busy                  high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16,
  parameter int RD_LAT = 2   // SRAM read latency, legal range 1..4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_f_req,
  input  logic [AWIDTH-1:0] i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_valid,
  output logic [DWIDTH-1:0] o_f_rdata,
  input  logic              i_x_req,
  input  logic              i_x_we,
  input  logic [AWIDTH-1:0] i_x_addr,
  input  logic [DWIDTH-1:0] i_x_wdata,
  output logic              o_x_gnt,
  output logic              o_x_valid,
  output logic [DWIDTH-1:0] o_x_rdata,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                win_x_q, win_x_d;     // 1: current access belongs to execute
  logic                last_x_q, last_x_d;   // 1: execute was granted last
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DWIDTH-1:0]   f_rdata_q, f_rdata_d;
  logic [DWIDTH-1:0]   x_rdata_q, x_rdata_d;
  logic                pick_x;

  // Execute wins when it is the only requester, or on a tie when fetch
  // was the last one served.
  assign pick_x = i_x_req & (~i_f_req | ~last_x_q);

  always_comb begin
    state_d   = state_q;
    win_x_d   = win_x_q;
    last_x_d  = last_x_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    f_rdata_d = f_rdata_q;
    x_rdata_d = x_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_f_req || i_x_req) begin
          state_d  = S_ISSUE;
          win_x_d  = pick_x;
          last_x_d = pick_x;
          addr_d   = pick_x ? i_x_addr : i_f_addr;
          we_d     = pick_x & i_x_we;   // fetch never writes
          wdata_d  = pick_x ? i_x_wdata : '0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (win_x_q) x_rdata_d = i_mem_rdata;
          else         f_rdata_d = i_mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      win_x_q   <= 1'b0;
      last_x_q  <= 1'b1;   // fetch wins the first tie
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      f_rdata_q <= '0;
      x_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_x_q   <= win_x_d;
      last_x_q  <= last_x_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      f_rdata_q <= f_rdata_d;
      x_rdata_q <= x_rdata_d;
    end
  end

  // All outputs decode from state and latched registers only.
  assign o_busy      = (state_q != S_IDLE);
  assign o_mem_cs    = (state_q == S_ISSUE);
  assign o_mem_we    = (state_q == S_ISSUE) & we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_f_gnt     = (state_q == S_ISSUE) & ~win_x_q;
  assign o_x_gnt     = (state_q == S_ISSUE) &  win_x_q;
  assign o_f_valid   = (state_q == S_DONE)  & ~win_x_q;
  assign o_x_valid   = (state_q == S_DONE)  &  win_x_q;
  assign o_f_rdata   = f_rdata_q;
  assign o_x_rdata   = x_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A main instance (RD_LAT=2)
//            runs against an SRAM model; two extra instances (RD_LAT=1, 4)
//            check read latency. Read data is scored through per-port queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        f_req, x_req, x_we;
  logic [11:0] f_addr, x_addr;
  logic [15:0] x_wdata;
  logic        f_gnt, f_valid, x_gnt, x_valid;
  logic [15:0] f_rdata, x_rdata;
  logic        mem_cs, mem_we, busy;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AWIDTH(12), .DWIDTH(16), .RD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_f_req(f_req), .i_f_addr(f_addr),
    .o_f_gnt(f_gnt), .o_f_valid(f_valid), .o_f_rdata(f_rdata),
    .i_x_req(x_req), .i_x_we(x_we), .i_x_addr(x_addr), .i_x_wdata(x_wdata),
    .o_x_gnt(x_gnt), .o_x_valid(x_valid), .o_x_rdata(x_rdata),
    .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // Latency instances: fetch-only traffic, execute port tied off.
  logic        a_req;
  logic [11:0] a_addr;
  logic        l1_fg, l1_fv, l1_xg, l1_xv, l1_cs, l1_we, l1_busy;
  logic [15:0] l1_fr, l1_xr, l1_wd, l1_rd;
  logic [11:0] l1_ad;
  logic        l4_fg, l4_fv, l4_xg, l4_xv, l4_cs, l4_we, l4_busy;
  logic [15:0] l4_fr, l4_xr, l4_wd, l4_rd;
  logic [11:0] l4_ad;

  mem_arbiter #(.AWIDTH(12), .DWIDTH(16), .RD_LAT(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .i_f_req(a_req), .i_f_addr(a_addr),
    .o_f_gnt(l1_fg), .o_f_valid(l1_fv), .o_f_rdata(l1_fr),
    .i_x_req(1'b0), .i_x_we(1'b0), .i_x_addr(12'h0), .i_x_wdata(16'h0),
    .o_x_gnt(l1_xg), .o_x_valid(l1_xv), .o_x_rdata(l1_xr),
    .o_mem_cs(l1_cs), .o_mem_we(l1_we), .o_mem_addr(l1_ad),
    .o_mem_wdata(l1_wd), .i_mem_rdata(l1_rd), .o_busy(l1_busy)
  );

  mem_arbiter #(.AWIDTH(12), .DWIDTH(16), .RD_LAT(4)) dut_l4 (
    .clk(clk), .reset_n(reset_n),
    .i_f_req(a_req), .i_f_addr(a_addr),
    .o_f_gnt(l4_fg), .o_f_valid(l4_fv), .o_f_rdata(l4_fr),
    .i_x_req(1'b0), .i_x_we(1'b0), .i_x_addr(12'h0), .i_x_wdata(16'h0),
    .o_x_gnt(l4_xg), .o_x_valid(l4_xv), .o_x_rdata(l4_xr),
    .o_mem_cs(l4_cs), .o_mem_we(l4_we), .o_mem_addr(l4_ad),
    .o_mem_wdata(l4_wd), .i_mem_rdata(l4_rd), .o_busy(l4_busy)
  );

  // ---------------------------------------------------------------- SRAM models
  function automatic logic [15:0] init_val(input logic [11:0] a);
    case (a)
      12'h010: init_val = 16'h1234;
      12'h001: init_val = 16'h1111;
      12'h002: init_val = 16'h2222;
      default: init_val = {4'h5, a};
    endcase
  endfunction

  function automatic logic [15:0] aux_val(input logic [11:0] a);
    aux_val = {4'hA, a} ^ 16'h0F0F;
  endfunction

  bit   [15:0] mem [4096];
  bit          wv  [4096];
  logic [15:0] m_p0, m_p1;
  always @(posedge clk) begin
    m_p1 <= m_p0;
    m_p0 <= 16'h0;
    if (mem_cs) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wv[mem_addr]  <= 1'b1;
      end else begin
        m_p0 <= wv[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      end
    end
  end
  assign mem_rdata = m_p1;

  logic [15:0] a1_p, a4_p0, a4_p1, a4_p2, a4_p3;
  always @(posedge clk) begin
    a1_p  <= (l1_cs & ~l1_we) ? aux_val(l1_ad) : 16'h0;
    a4_p0 <= (l4_cs & ~l4_we) ? aux_val(l4_ad) : 16'h0;
    a4_p1 <= a4_p0;
    a4_p2 <= a4_p1;
    a4_p3 <= a4_p2;
  end
  assign l1_rd = a1_p;
  assign l4_rd = a4_p3;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input bit is_x, input string tag);
    int n;
    n = 0;
    while (!(is_x ? x_valid : f_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, is_x ? x_valid : f_valid, 1);
  endtask

  // Scoreboard: expected response data per port, popped on each valid pulse.
  logic [15:0] qf[$];
  logic [15:0] qx[$];
  logic [15:0] ef, ex;
  always @(negedge clk) begin
    if (reset_n) begin
      if (f_valid) begin
        if (qf.size() == 0) chk("f_valid_unexpected", 1, 0);
        else begin
          ef = qf.pop_front();
          chk("f_rdata_sb", f_rdata, ef);
        end
      end
      if (x_valid) begin
        if (qx.size() == 0) chk("x_valid_unexpected", 1, 0);
        else begin
          ex = qx.pop_front();
          chk("x_rdata_sb", x_rdata, ex);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n = 1'b0;
    f_req = 1'b0; f_addr = '0;
    x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
    a_req = 1'b0; a_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, mem_cs, mem_we, f_gnt, x_gnt, f_valid, x_valid}, 0);
    chk("reset_rdata", {f_rdata, x_rdata}, 0);
    reset_n = 1'b1;
    tick();

    // Single fetch read, RD_LAT=2
    f_req = 1'b1; f_addr = 12'h010; qf.push_back(16'h1234); cyc = 0;
    tick();
    chk("f_issue_ctrl", {mem_cs, mem_we, f_gnt, x_gnt, busy}, 5'b10101);
    chk("f_issue_addr", mem_addr, 12'h010);
    tick(); tick();
    chk("f_no_early_valid", f_valid, 0);
    tick();
    chk("f_valid_cyc4", {f_valid, x_valid, x_gnt}, 3'b100);
    chk("f_rdata_cyc4", f_rdata, 16'h1234);
    f_req = 1'b0;
    tick();
    chk("f_idle_after", {busy, f_valid}, 0);
    chk("f_rdata_hold", f_rdata, 16'h1234);

    // Tie after a fetch grant: execute wins; it is a write
    f_req = 1'b1; f_addr = 12'h001;
    x_req = 1'b1; x_we = 1'b1; x_addr = 12'h020; x_wdata = 16'hBEEF;
    qx.push_back(16'h0000);   // a write leaves x_rdata at its previous value
    tick();
    chk("x_wr_issue_ctrl", {mem_cs, mem_we, f_gnt, x_gnt}, 4'b1101);
    chk("x_wr_issue_addr", mem_addr, 12'h020);
    chk("x_wr_issue_wdata", mem_wdata, 16'hBEEF);
    tick();
    chk("x_wr_valid_cyc2", {x_valid, f_valid}, 2'b10);
    x_req = 1'b0; x_we = 1'b0;
    tick();
    qf.push_back(16'h1111);
    tick();
    chk("f_loser_granted", {f_gnt, x_gnt, mem_we}, 3'b100);
    chk("f_loser_addr", mem_addr, 12'h001);
    wait_valid(1'b0, "f_loser_valid");
    f_addr = 12'h020; qf.push_back(16'hBEEF);
    f_req = 1'b0;
    tick();
    f_req = 1'b1;
    wait_valid(1'b0, "f_readback_valid");
    f_req = 1'b0;
    tick();

    // Reset, then both requesting: fetch, execute, fetch, execute
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    f_req = 1'b1; f_addr = 12'h002; qf.push_back(16'h2222);
    x_req = 1'b1; x_we = 1'b0; x_addr = 12'h001; qx.push_back(16'h1111);
    tick();
    chk("tie1_first", {f_gnt, x_gnt}, 2'b10);
    wait_valid(1'b0, "tie1_f_valid");
    f_req = 1'b0;
    tick(); tick();
    chk("tie1_second", {f_gnt, x_gnt}, 2'b01);
    wait_valid(1'b1, "tie1_x_valid");
    f_req = 1'b1; f_addr = 12'h010; qf.push_back(16'h1234);
    x_addr = 12'h002; qx.push_back(16'h2222);
    tick(); tick();
    chk("tie2_first", {f_gnt, x_gnt}, 2'b10);
    wait_valid(1'b0, "tie2_f_valid");
    f_req = 1'b0;
    tick(); tick();
    chk("tie2_second", {f_gnt, x_gnt}, 2'b01);
    wait_valid(1'b1, "tie2_x_valid");
    x_req = 1'b0;
    tick();

    // Back-to-back fetch reads: valid at cycles 4 and 9
    f_req = 1'b1; f_addr = 12'h001; qf.push_back(16'h1111); cyc = 0;
    tick(); tick(); tick();
    chk("b2b_not_yet_3", f_valid, 0);
    tick();
    chk("b2b_valid_cyc4", f_valid, 1);
    f_req = 1'b0;
    tick();
    f_req = 1'b1; f_addr = 12'h002; qf.push_back(16'h2222);
    tick(); tick(); tick();
    chk("b2b_not_yet_8", f_valid, 0);
    tick();
    chk("b2b_valid_cyc9", {f_valid, cyc[3:0]}, {1'b1, 4'd9});
    f_req = 1'b0;
    tick();

    // Reset during WAIT aborts the access
    f_req = 1'b1; f_addr = 12'h010; qf.push_back(16'h1234);
    tick(); tick();
    chk("rst_pre_wait", {busy, mem_cs}, 2'b10);
    f_req = 1'b0;
    #2;
    reset_n = 1'b0;
    qf.delete();
    #1;
    chk("rst_mid_ctrl", {busy, mem_cs, mem_we, f_gnt, x_gnt, f_valid, x_valid}, 0);
    chk("rst_mid_rdata", {f_rdata, x_rdata}, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_valid", {f_valid, busy}, 0);
    end
    f_req = 1'b1; f_addr = 12'h001; qf.push_back(16'h1111);
    x_req = 1'b1; x_we = 1'b0; x_addr = 12'h002; qx.push_back(16'h2222);
    tick();
    chk("rst_tie_fetch", {f_gnt, x_gnt}, 2'b10);
    wait_valid(1'b0, "rst_tie_f_valid");
    f_req = 1'b0;
    tick(); tick();
    chk("rst_tie_exec", {f_gnt, x_gnt}, 2'b01);
    wait_valid(1'b1, "rst_tie_x_valid");
    x_req = 1'b0;
    tick();

    // Latency variants: RD_LAT=1 valid at cycle 3, RD_LAT=4 at cycle 6
    a_req = 1'b1; a_addr = 12'h033; cyc = 0;
    tick();
    chk("lat_issue", {l1_fg, l4_fg, l1_we, l4_we}, 4'b1100);
    tick();
    chk("lat1_not_yet", l1_fv, 0);
    tick();
    chk("lat1_valid_cyc3", {l1_fv, l1_xv}, 2'b10);
    chk("lat1_rdata", l1_fr, aux_val(12'h033));
    a_req = 1'b0;
    tick(); tick();
    chk("lat4_not_yet", l4_fv, 0);
    tick();
    chk("lat4_valid_cyc6", {l4_fv, l4_xv}, 2'b10);
    chk("lat4_rdata", l4_fr, aux_val(12'h033));
    tick();

    chk("sb_drained", qf.size() + qx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
